// File: rtl/comparator_pkg.sv
// Shared types for the serial comparator: FSM state encoding and result codes.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

endpackage

// File: rtl/serial_comparator_if.sv
// Request/result bundle of the serial comparator; master drives operands, slave returns flags.
interface serial_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/comparator_bit_cell.sv
// Single-bit compare decision; at the signed MSB the sign bit reverses which operand wins.
module comparator_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  output logic differ,
  output logic a_wins
);

  assign differ = a_bit ^ b_bit;
  // A set sign bit means the more negative operand, so B's bit decides who wins.
  assign a_wins = (is_msb && signed_mode) ? b_bit : a_bit;

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator (unsigned or two's complement).
// Build option: COMPARATOR_EARLY_EXIT_EN ends the scan right after the first differing bit.
//
// state | meaning
// IDLE  | waiting for start
// CMP   | scanning one operand bit per cycle, MSB first
// DONE  | result valid for one cycle; start here launches the next compare
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_comparator_if.slave bus
);

  localparam int              IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]   MSB_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic             bit_differ;
  logic             bit_a_wins;
  logic [1:0]       cur_res;
  logic             finish;

  comparator_bit_cell u_bit_cell (
    .a_bit       (a_q[idx_q]),
    .b_bit       (b_q[idx_q]),
    .is_msb      (idx_q == MSB_IDX),
    .signed_mode (sm_q),
    .differ      (bit_differ),
    .a_wins      (bit_a_wins)
  );

  // Once a decision is recorded, lower bits no longer matter.
  always_comb begin
    cur_res = res_q;
    if (res_q == RES_EQ && bit_differ) begin
      cur_res = bit_a_wins ? RES_GT : RES_LT;
    end
  end

`ifdef COMPARATOR_EARLY_EXIT_EN
  assign finish = (idx_q == '0) || (cur_res != RES_EQ);
`else
  assign finish = (idx_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    idx_d   = idx_q;
    res_d   = res_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sm_d    = bus.signed_mode;
          idx_d   = MSB_IDX;
          res_d   = RES_EQ;
          state_d = CMP;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CMP: begin
        res_d = cur_res;
        if (finish) begin
          state_d = DONE;
          eq_d    = (cur_res == RES_EQ);
          gt_d    = (cur_res == RES_GT);
          lt_d    = (cur_res == RES_LT);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= RES_EQ;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.busy = (state_q == CMP);
  assign bus.done = (state_q == DONE);
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request a comparison of the current a/b/signed_mode.
REQ-005 Port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port busy  output  1  high while a comparison is in progress (CMP state).
REQ-009 Port done  output  1  one-cycle pulse marking a valid result.
REQ-010 Port eq, gt, lt  output  1 each  result flags for A==B, A>B and A<B.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-012 start SHALL be accepted in IDLE or DONE, which captures a, b and signed_mode, loads bit index WIDTH-1 and enters CMP.
REQ-013 start in CMP SHALL be ignored; captured operands SHALL NOT change during CMP.
REQ-014 CMP SHALL examine one bit per cycle, MSB first, and the first differing bit SHALL decide the result.
REQ-015 At the MSB with signed_mode=1, a differing bit SHALL decide the result inverted: A bit 1 gives lt, B bit 1 gives gt.
REQ-016 At any other bit, or with signed_mode=0, a differing bit SHALL give gt if the A bit is 1 and lt otherwise.
REQ-017 If no bit differs after bit 0, the result SHALL be eq.
REQ-018 CMP -> DONE SHALL occur after bit 0 is examined (or earlier, per REQ-026); DONE -> IDLE SHALL follow after one cycle unless start is asserted.
REQ-019 done SHALL be 1 only in DONE; busy SHALL be 1 only in CMP.
REQ-020 eq/gt/lt SHALL be registered, update on entry to DONE, and hold until the next entry to DONE.
REQ-021 After any completion, exactly one of eq/gt/lt SHALL be 1.
REQ-022 With start accepted at edge T and no early exit, done SHALL be high in cycle T+WIDTH+1.
REQ-023 start asserted in DONE SHALL start a back-to-back comparison; done still pulses in that cycle and busy rises next cycle.

Reset
REQ-024 When rst=1 at an edge, the next state SHALL be IDLE, with busy=0, done=0, eq=0, gt=0, lt=0, and captured operands and bit index cleared.
REQ-025 rst SHALL take priority over start; reset during CMP SHALL abort the comparison with no done pulse.

Configuration
REQ-026 Macro COMPARATOR_EARLY_EXIT_EN defined: CMP SHALL go to DONE on the cycle after the first differing bit k (MSB = WIDTH-1), so done is high at T+(WIDTH-k)+1; equal operands still take T+WIDTH+1.
REQ-027 Macro COMPARATOR_EARLY_EXIT_EN undefined: latency SHALL be constant at T+WIDTH+1 for all operands, with the result still fixed by the first differing bit.

Structure
REQ-028 Shared package comparator_pkg SHALL hold the state typedef (IDLE, CMP, DONE) and the result-code constants (RES_EQ, RES_GT, RES_LT).
REQ-029 Per-bit decision logic SHALL be one combinational sub-module, comparator_bit_cell.
- Inputs: a_bit, b_bit, is_msb, signed_mode.
- Outputs: differ, a_wins.

Verification (WIDTH=8 unless stated)
REQ-030 Equal operands: a=0x5A, b=0x5A, unsigned, start at T -> busy high T+1..T+8; done at T+9 with eq=1, gt=0, lt=0 (both builds).
REQ-031 Signed vs unsigned: a=0x80, b=0x7F.
- Unsigned -> gt=1.
- Signed -> lt=1.
- With COMPARATOR_EARLY_EXIT_EN, done at T+2; without it, done at T+9.
REQ-032 LSB difference: a=0x03, b=0x02 -> gt=1 with done at T+9 in both builds.
- Immediately restarting in the DONE cycle with a=0x02, b=0x03 -> lt=1 at T+18.
REQ-033 Ignored start: start pulsed at T+3 with a=0xFF, b=0x00 during a 0x10-vs-0x20 compare -> done at T+9 with lt=1 only, and no second done.
REQ-034 Reset abort: rst high at T+4 mid-CMP -> at T+5 busy=0, eq=gt=lt=0, and done never pulses for that operation.
REQ-035 Exhaustive: WIDTH=2 instance, all 16 a/b pairs in both modes -> flags match the 2-bit truth table (signed range -2..1).
